// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the burst reader and the syncRAM it reads from:
// read-port count, default address/data widths and the reader state encoding.
package ram_burst_reader_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;
    localparam int IDX_W      = $clog2(NUM_PORTS);
    localparam int GRP_W      = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DRAIN,
        DONE
    } burstState_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Request, RAM read-port and output-stream signals of the burst reader.
// master = the reader itself, slave = the RAM/requester/stream environment.
interface ram_burst_reader_if import ram_burst_reader_pkg::*; #(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] startAddr;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] readAddr_0;
    logic [ADDR_W-1:0] readAddr_1;
    logic [ADDR_W-1:0] readAddr_2;
    logic [ADDR_W-1:0] readAddr_3;
    logic              readEnable;
    logic [DATA_W-1:0] dOut_0;
    logic [DATA_W-1:0] dOut_1;
    logic [DATA_W-1:0] dOut_2;
    logic [DATA_W-1:0] dOut_3;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic              busy;
    logic              done;

    modport master (
        input  start, startAddr, length, dOut_0, dOut_1, dOut_2, dOut_3, outReady,
        output readAddr_0, readAddr_1, readAddr_2, readAddr_3, readEnable,
               outData, outValid, busy, done
    );

    modport slave (
        output start, startAddr, length, dOut_0, dOut_1, dOut_2, dOut_3, outReady,
        input  readAddr_0, readAddr_1, readAddr_2, readAddr_3, readEnable,
               outData, outValid, busy, done
    );

endinterface

// File: rtl/ram_burst_reader_group_buffer.sv
// Holds one captured group of RAM words and steps through the bytes of it
// that still belong to the burst (min(NUM_PORTS, remaining)).
module burst_group_buffer import ram_burst_reader_pkg::*; #(
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = 9
) (
    input  logic                             Clk,
    input  logic                             reset,
    input  logic                             capture,
    input  logic                             advance,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] dIn,
    input  logic [LEN_W-1:0]                 remaining,
    output logic [DATA_W-1:0]                headData,
    output logic [GRP_W-1:0]                 groupSize,
    output logic                             lastByte
);

    logic [NUM_PORTS-1:0][DATA_W-1:0] buffer;
    logic [IDX_W-1:0]                 idx;

    function automatic logic [GRP_W-1:0] groupOf(input logic [LEN_W-1:0] rem);
        if (rem >= LEN_W'(NUM_PORTS))
            return GRP_W'(NUM_PORTS);
        return rem[GRP_W-1:0];
    endfunction

    always_ff @(posedge Clk) begin
        if (reset) begin
            buffer    <= '0;
            idx       <= '0;
            groupSize <= '0;
        end else if (capture) begin
            buffer    <= dIn;
            idx       <= '0;
            groupSize <= groupOf(remaining);
        end else if (advance) begin
            idx <= lastByte ? '0 : idx + IDX_W'(1);
        end
    end

    assign headData = buffer[idx];
    assign lastByte = (GRP_W'(idx) == groupSize - GRP_W'(1));

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of bytes from a 4-port synchronous RAM, four addresses per
// read, and streams them out in ascending (wrapping) address order.
module ram_burst_reader import ram_burst_reader_pkg::*; #(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = 9
) (
    input  logic               Clk,
    input  logic               reset,
    ram_burst_reader_if.master bus
);

    burstState_t                      state, stateNext;
    logic [ADDR_W-1:0]                base, baseNext;
    logic [LEN_W-1:0]                 remaining, remainingNext;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addrIssue, addrHold;
    logic [NUM_PORTS-1:0][DATA_W-1:0] ramData;
    logic [GRP_W-1:0]                 groupSize;
    logic                             lastByte;
    logic                             fire;

    assign ramData = {bus.dOut_3, bus.dOut_2, bus.dOut_1, bus.dOut_0};

    always_comb begin
        addrIssue = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            addrIssue[i] = base + ADDR_W'(i);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            remaining <= '0;
            addrHold  <= '0;
        end else begin
            state     <= stateNext;
            base      <= baseNext;
            remaining <= remainingNext;
            if (state == ISSUE)
                addrHold <= addrIssue;
        end
    end

    always_comb begin
        stateNext     = state;
        baseNext      = base;
        remainingNext = remaining;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    baseNext      = bus.startAddr;
                    remainingNext = bus.length;
                    stateNext     = (bus.length == '0) ? DONE : ISSUE;
                end
            end
            ISSUE:   stateNext = CAPTURE;
            CAPTURE: stateNext = DRAIN;
            DRAIN: begin
                // Group retires on the handshake of its final byte.
                if (fire && lastByte) begin
                    remainingNext = remaining - LEN_W'(groupSize);
                    baseNext      = base + ADDR_W'(NUM_PORTS);
                    stateNext     = (remainingNext == '0) ? DONE : ISSUE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Addresses are live only while reading; afterwards the last set is held.
    assign bus.readAddr_0 = (state == ISSUE) ? addrIssue[0] : addrHold[0];
    assign bus.readAddr_1 = (state == ISSUE) ? addrIssue[1] : addrHold[1];
    assign bus.readAddr_2 = (state == ISSUE) ? addrIssue[2] : addrHold[2];
    assign bus.readAddr_3 = (state == ISSUE) ? addrIssue[3] : addrHold[3];
    assign bus.readEnable = (state == ISSUE);
    assign bus.outValid   = (state == DRAIN);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign fire           = bus.outValid && bus.outReady;

    burst_group_buffer #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) groupBuffer (
        .Clk      (Clk),
        .reset    (reset),
        .capture  (state == CAPTURE),
        .advance  (fire),
        .dIn      (ramData),
        .remaining(remaining),
        .headData (bus.outData),
        .groupSize(groupSize),
        .lastByte (lastByte)
    );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural 4-port syncRAM and a
// byte scoreboard filled from the RAM image when each burst is requested.
module tb_ram_burst_reader;

    logic Clk = 1'b0;
    logic reset;

    always #5 Clk = ~Clk;

    ram_burst_reader_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) bus ();

    ram_burst_reader #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] mem [256];

    always @(posedge Clk) begin
        if (bus.readEnable) begin
            bus.dOut_0 <= mem[bus.readAddr_0];
            bus.dOut_1 <= mem[bus.readAddr_1];
            bus.dOut_2 <= mem[bus.readAddr_2];
            bus.dOut_3 <= mem[bus.readAddr_3];
        end
    end

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int tStart;
    int firstValidCyc, lastByteCyc, doneCyc;
    int doneCnt, issueCnt, validCnt, busyCnt, byteCnt;
    logic [7:0] sb [$];
    logic [7:0] expIssueAddr;
    logic [7:0] heldData;
    bit         stalled = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        firstValidCyc = -1;
        lastByteCyc   = -1;
        doneCyc       = -1;
        doneCnt       = 0;
        issueCnt      = 0;
        validCnt      = 0;
        busyCnt       = 0;
        byteCnt       = 0;
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [7:0] a3;
        logic [7:0] expByte;
        @(negedge Clk);
        cyc++;
        if (bus.readEnable) begin
            issueCnt++;
            a3 = expIssueAddr + 8'd3;
            check("readAddr_0", 32'(bus.readAddr_0), 32'(expIssueAddr));
            check("readAddr_3", 32'(bus.readAddr_3), 32'(a3));
            expIssueAddr = expIssueAddr + 8'd4;
        end
        if (stalled) begin
            check("stallValid", 32'(bus.outValid), 32'd1);
            check("stallData", 32'(bus.outData), 32'(heldData));
        end
        if (bus.outValid) begin
            validCnt++;
            if (firstValidCyc < 0) firstValidCyc = cyc;
        end
        if (bus.outValid && bus.outReady && !reset) begin
            byteCnt++;
            lastByteCyc = cyc;
            if (sb.size() == 0) begin
                check("extraByte", 32'(bus.outData), 32'hFFFF_FFFF);
            end else begin
                expByte = sb.pop_front();
                check("outData", 32'(bus.outData), 32'(expByte));
            end
        end
        if (bus.done) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (bus.busy) busyCnt++;
        stalled  = bus.outValid && !bus.outReady && !reset;
        heldData = bus.outData;
        @(posedge Clk);
        #1;
    endtask

    task automatic runBurst(input string tag, input logic [7:0] a, input logic [8:0] n,
                            input bit toggle, input bit midStart);
        int nInt;
        logic [7:0] ad;
        nInt = int'(n);
        sb.delete();
        clearStats();
        for (int k = 0; k < nInt; k++) begin
            ad = a + 8'(k);
            sb.push_back(mem[ad]);
        end
        expIssueAddr  = a;
        bus.startAddr = a;
        bus.length    = n;
        bus.start     = 1'b1;
        bus.outReady  = 1'b1;
        tick();
        tStart    = cyc;
        bus.start = 1'b0;
        for (int k = 0; k < 400 && doneCnt == 0; k++) begin
            if (toggle) bus.outReady = ~bus.outReady;
            if (midStart && k == 4) begin
                bus.start     = 1'b1;
                bus.startAddr = 8'h33;
                bus.length    = 9'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start    = 1'b0;
        bus.outReady = 1'b1;
        tick();
        check({tag, ".doneCount"}, 32'(doneCnt), 32'd1);
        check({tag, ".sbEmpty"}, 32'(sb.size()), 32'd0);
        check({tag, ".bytes"}, 32'(byteCnt), 32'(nInt));
        check({tag, ".issues"}, 32'(issueCnt), 32'((nInt + 3) / 4));
        if (nInt != 0) begin
            check({tag, ".firstValid"}, 32'(firstValidCyc), 32'(tStart + 3));
            check({tag, ".doneAfterLast"}, 32'(doneCyc), 32'(lastByteCyc + 1));
        end else begin
            check({tag, ".doneAt"}, 32'(doneCyc), 32'(tStart + 1));
            check({tag, ".busyCycles"}, 32'(busyCnt), 32'd1);
            check({tag, ".noValid"}, 32'(validCnt), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        mem[1] = 8'h01;
        mem[2] = 8'h10;
        mem[3] = 8'h06;
        mem[4] = 8'h12;
        expIssueAddr  = 8'h00;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.startAddr = 8'h00;
        bus.length    = 9'd0;
        bus.outReady  = 1'b0;
        clearStats();
        repeat (3) tick();

        @(negedge Clk);
        check("rst.outValid", 32'(bus.outValid), 32'd0);
        check("rst.outData", 32'(bus.outData), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.readEnable", 32'(bus.readEnable), 32'd0);
        check("rst.readAddr_0", 32'(bus.readAddr_0), 32'd0);
        check("rst.readAddr_3", 32'(bus.readAddr_3), 32'd0);
        @(posedge Clk);
        #1;
        reset = 1'b0;
        tick();

        runBurst("basic4", 8'h01, 9'd4, 1'b0, 1'b0);
        runBurst("wrap6", 8'hFE, 9'd6, 1'b0, 1'b1);
        runBurst("len5", 8'h20, 9'd5, 1'b0, 1'b0);
        runBurst("len0", 8'h50, 9'd0, 1'b0, 1'b0);
        runBurst("stall8", 8'h40, 9'd8, 1'b1, 1'b0);
        runBurst("len258", 8'hF0, 9'd258, 1'b0, 1'b0);

        // Abort a burst after two bytes, then confirm silence and recovery.
        sb.delete();
        clearStats();
        for (int k = 0; k < 8; k++) sb.push_back(mem[8'h10 + 8'(k)]);
        expIssueAddr  = 8'h10;
        bus.startAddr = 8'h10;
        bus.length    = 9'd8;
        bus.start     = 1'b1;
        bus.outReady  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 50 && byteCnt < 2; k++) tick();
        check("abort.reached", 32'(byteCnt), 32'd2);
        bus.outReady = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        bus.outReady = 1'b1;
        sb.delete();
        clearStats();
        repeat (6) tick();
        check("abort.outValid", 32'(validCnt), 32'd0);
        check("abort.busy", 32'(busyCnt), 32'd0);
        check("abort.done", 32'(doneCnt), 32'd0);
        check("abort.readEnable", 32'(issueCnt), 32'd0);

        runBurst("afterAbort", 8'h80, 9'd4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM/stream data width.
REQ-003 SHALL have parameter LEN_W, default 9, burst length field width.
REQ-004 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-007 SHALL have port startAddr  input  ADDR_W  first RAM address of burst.
REQ-008 SHALL have port length  input  LEN_W  bytes to read; 0 legal.
REQ-009 SHALL have ports readAddr_0..readAddr_3  output  ADDR_W each  RAM read addresses.
REQ-010 SHALL have port readEnable  output  1  RAM read enable.
REQ-011 SHALL have ports dOut_0..dOut_3  input  DATA_W each  RAM read data.
REQ-012 SHALL have port outData  output  DATA_W  stream byte.
REQ-013 SHALL have port outValid  output  1  outData valid.
REQ-014 SHALL have port outReady  input  1  downstream accept.
REQ-015 SHALL have port busy  output  1  high outside IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-017 SHALL implement states IDLE, ISSUE, CAPTURE, DRAIN, DONE.
REQ-018 IDLE: start=1 latches startAddr and length; length=0 -> DONE, else -> ISSUE.
REQ-019 ISSUE, one cycle: readAddr_i = (base+i) mod 2^ADDR_W, i=0..3; readEnable=1; -> CAPTURE.
REQ-020 SHALL treat RAM read latency as exactly one cycle: dOut_i valid in the cycle after ISSUE.
REQ-021 CAPTURE, one cycle: latch dOut_0..3 into 4-entry buffer; group size = min(4, remaining); -> DRAIN.
REQ-022 DRAIN: outData = buffer[idx], idx starting at 0; outValid=1; byte transfers when outValid&&outReady.
REQ-023 outData/outValid SHALL stay stable while outValid=1 and outReady=0.
REQ-024 On the last group byte's transfer: remaining -= group size, base += 4 mod 2^ADDR_W; remaining=0 -> DONE, else -> ISSUE.
REQ-025 Bytes SHALL be emitted in ascending address order, wrapping 0xFF->0x00; length>256 re-reads wrapped addresses.
REQ-026 Partial final group (<4): only remaining bytes emitted; surplus port data discarded.
REQ-027 DONE, one cycle: done=1, busy=1; -> IDLE; done=0 in all other states.
REQ-028 readEnable SHALL be 0 outside ISSUE; readAddr_i hold last value outside ISSUE.
REQ-029 start SHALL be ignored outside IDLE; startAddr/length changes mid-burst have no effect.
REQ-030 Latency: start at edge t -> ISSUE during t+1, CAPTURE t+2, first outValid t+3; with outReady=1, a 4-byte group every 6 cycles.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, regardless of state, including mid-burst.
REQ-032 Reset values SHALL be: outValid=0, outData=0, busy=0, done=0, readEnable=0, readAddr_0..3=0, buffer/idx/base/remaining=0.
REQ-033 A burst aborted by reset SHALL produce no further bytes and no done pulse.

Structure
REQ-034 State encoding, and the port count 4 and address/data widths, SHALL be defined in a shared package, common with syncRAM.
REQ-035 The 4-entry buffer with index and group-size logic SHALL be one sub-module, burst_group_buffer; FSM and address generation stay in the top.

Verification
REQ-036 syncRAM preloaded with addr 1..4 = 01,10,06,12; start, startAddr=1, length=4, outReady=1 -> stream 01,10,06,12, first outValid at t+3, done one cycle after last byte.
REQ-037 startAddr=0xFE, length=6 -> reads 0xFE,0xFF,0x00,0x01,0x02,0x03 in order; two ISSUE cycles.
REQ-038 length=5 -> 5 bytes; the second group emits only one byte; done after it.
REQ-039 length=0 -> no readEnable, no outValid; done pulses at t+1; busy high only that cycle.
REQ-040 outReady toggled 0/1 each cycle during DRAIN -> no byte lost or duplicated; outData stable while stalled.
REQ-041 reset asserted in DRAIN after 2 bytes -> next cycle outValid=0, busy=0, no done; a fresh start then works normally.
